// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: pipeline hazard detection and forwarding controller for the
// 5-stage core. Tracks the destinations of the instructions in EX and MEM,
// decides stall / bubble for the decode-stage instruction, and registers the
// EX operand forward selects as the decode instruction advances into EX.
module hazard_fwd_unit #(
   parameter int REG_AW  = 3,
   parameter bit FWD_EN  = 1'b1,
   parameter bit R0_ZERO = 1'b0,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs_addr,
   input  logic [REG_AW-1:0] id_rt_addr,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_wr_addr,
   input  logic [1:0]        id_res_cls,
   input  logic              mem_busy,
   input  logic              flush,
   output logic              stall,
   output logic              bubble,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [1:0]        fwd_a_cls,
   output logic [1:0]        fwd_b_cls,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0]       CLS_LOAD  = 2'd3;
   localparam logic [1:0]       SEL_RF    = 2'd0;
   localparam logic [1:0]       SEL_EXMEM = 2'd1;
   localparam logic [1:0]       SEL_MEMWB = 2'd2;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [REG_AW-1:0] addr;
      logic [1:0]        cls;
   } sb_entry_t;

   sb_entry_t ex_q;
   sb_entry_t mem_q;
   sb_entry_t ex_d;

   logic       rs_ex, rt_ex, rs_mem, rt_mem;
   logic       hazard;
   logic       count_en;
   logic [1:0] a_sel_d, b_sel_d, a_cls_d, b_cls_d;

   // A source depends on an entry when it reads the register that entry will write.
   function automatic logic match(input logic used, input logic [REG_AW-1:0] src,
                                  input sb_entry_t e);
      return used & e.valid & e.wr & (e.addr == src) & ~(R0_ZERO & (src == '0));
   endfunction

   // Dependence checks, hazard decision and the stall/bubble controls for this cycle.
   always_comb begin
      rs_ex  = match(id_rs_used, id_rs_addr, ex_q);
      rt_ex  = match(id_rt_used, id_rt_addr, ex_q);
      rs_mem = match(id_rs_used, id_rs_addr, mem_q);
      rt_mem = match(id_rt_used, id_rt_addr, mem_q);
      if (FWD_EN)
         hazard = id_valid & (rs_ex | rt_ex) & (ex_q.cls == CLS_LOAD);
      else
         hazard = id_valid & (rs_ex | rt_ex | rs_mem | rt_mem);
      stall    = mem_busy | (hazard & ~flush);
      bubble   = ~mem_busy & (flush | hazard | ~id_valid);
      count_en = hazard & ~flush & ~mem_busy;
   end

   // Forward selects for the instruction about to enter EX; the youngest producer wins.
   always_comb begin
      a_sel_d = SEL_RF;
      a_cls_d = 2'd0;
      b_sel_d = SEL_RF;
      b_cls_d = 2'd0;
      if (FWD_EN && !bubble) begin
         if (rs_ex) begin
            a_sel_d = SEL_EXMEM;
            a_cls_d = ex_q.cls;
         end else if (rs_mem) begin
            a_sel_d = SEL_MEMWB;
            a_cls_d = mem_q.cls;
         end
         if (rt_ex) begin
            b_sel_d = SEL_EXMEM;
            b_cls_d = ex_q.cls;
         end else if (rt_mem) begin
            b_sel_d = SEL_MEMWB;
            b_cls_d = mem_q.cls;
         end
      end
   end

   // Entry that moves into EX: the decode instruction, or an empty slot for a bubble.
   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid = 1'b1;
         ex_d.wr    = id_wr_en;
         ex_d.addr  = id_wr_addr;
         ex_d.cls   = id_res_cls;
      end
   end

   // Scoreboard shift; a busy data memory freezes the whole pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
      end else if (!mem_busy) begin
         mem_q <= ex_q;
         ex_q  <= ex_d;
      end
   end

   // Forward selects are registered so they line up with the consumer sitting in EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_sel <= SEL_RF;
         fwd_a_cls <= 2'd0;
         fwd_b_sel <= SEL_RF;
         fwd_b_cls <= 2'd0;
      end else if (!mem_busy) begin
         fwd_a_sel <= a_sel_d;
         fwd_a_cls <= a_cls_d;
         fwd_b_sel <= b_sel_d;
         fwd_b_cls <= b_cls_d;
      end
   end

   // Saturating count of cycles lost to hazard stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (count_en && stall_cnt != CNT_MAX)
         stall_cnt <= stall_cnt + CNT_ONE;
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: drives two hazard_fwd_unit instances (forwarding with
// 8-bit counter, and no-forwarding with r0 exempt and a 2-bit counter) from the
// same decode stream and compares both against an instruction-level model.
module tb_hazard_fwd_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_rs_used, id_rt_used, id_wr_en, mem_busy, flush;
   logic [2:0] id_rs_addr, id_rt_addr, id_wr_addr;
   logic [1:0] id_res_cls;

   logic       stall0, bubble0, stall1, bubble1;
   logic [1:0] a_sel0, a_cls0, b_sel0, b_cls0;
   logic [1:0] a_sel1, a_cls1, b_sel1, b_cls1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   bit drv_done = 1'b0;

   // Clock generation
   always #5 clk = ~clk;

   hazard_fwd_unit dut_fwd (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_res_cls(id_res_cls),
      .mem_busy(mem_busy), .flush(flush), .stall(stall0), .bubble(bubble0),
      .fwd_a_sel(a_sel0), .fwd_b_sel(b_sel0), .fwd_a_cls(a_cls0), .fwd_b_cls(b_cls0),
      .stall_cnt(cnt0));

   hazard_fwd_unit #(.REG_AW(3), .FWD_EN(1'b0), .R0_ZERO(1'b1), .CNT_W(2)) dut_nofwd (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_res_cls(id_res_cls),
      .mem_busy(mem_busy), .flush(flush), .stall(stall1), .bubble(bubble1),
      .fwd_a_sel(a_sel1), .fwd_b_sel(b_sel1), .fwd_a_cls(a_cls1), .fwd_b_cls(b_cls1),
      .stall_cnt(cnt1));

   // Instruction-level reference model: what is in flight, per instance
   typedef struct packed {
      bit       v;
      bit       wr;
      bit [2:0] addr;
      bit [1:0] cls;
   } instr_t;

   typedef struct {
      int stall, bubble, a_sel, a_cls, b_sel, b_cls, cnt;
   } obs_t;

   instr_t in_ex[2];
   instr_t in_mem[2];
   int     m_asel[2], m_acls[2], m_bsel[2], m_bcls[2], m_cnt[2];
   int     cnt_max[2] = '{255, 3};
   bit     fwd_on[2]  = '{1'b1, 1'b0};
   bit     r0_free[2] = '{1'b0, 1'b1};
   obs_t   exp_q0[$];
   obs_t   exp_q1[$];

   function automatic bit produces(int k, instr_t e, bit used, int src);
      return used && e.v && e.wr && (int'(e.addr) == src) && !(r0_free[k] && src == 0);
   endfunction

   function automatic bit model_hazard(int k);
      bit dep_ex, dep_mem;
      dep_ex  = produces(k, in_ex[k], id_rs_used, id_rs_addr) ||
                produces(k, in_ex[k], id_rt_used, id_rt_addr);
      dep_mem = produces(k, in_mem[k], id_rs_used, id_rs_addr) ||
                produces(k, in_mem[k], id_rt_used, id_rt_addr);
      if (fwd_on[k])
         return id_valid && dep_ex && in_ex[k].cls == 2'd3;
      return id_valid && (dep_ex || dep_mem);
   endfunction

   function automatic bit model_bubble(int k);
      return !mem_busy && (flush || model_hazard(k) || !id_valid);
   endfunction

   // Where the operand comes from once the consumer reaches EX
   task automatic modelSource(input int k, input bit used, input int src,
                              output int sel, output int cls);
      sel = 0;
      cls = 0;
      if (fwd_on[k] && !model_bubble(k)) begin
         if (produces(k, in_mem[k], used, src)) begin
            sel = 2;
            cls = in_mem[k].cls;
         end
         if (produces(k, in_ex[k], used, src)) begin
            sel = 1;
            cls = in_ex[k].cls;
         end
      end
   endtask

   task automatic modelReset(input int k);
      in_ex[k]  = '0;
      in_mem[k] = '0;
      m_asel[k] = 0; m_acls[k] = 0; m_bsel[k] = 0; m_bcls[k] = 0; m_cnt[k] = 0;
   endtask

   task automatic modelExpect(input int k, output obs_t o);
      bit haz;
      haz      = model_hazard(k);
      o.stall  = (mem_busy || (haz && !flush)) ? 1 : 0;
      o.bubble = model_bubble(k) ? 1 : 0;
      o.a_sel  = m_asel[k];
      o.a_cls  = m_acls[k];
      o.b_sel  = m_bsel[k];
      o.b_cls  = m_bcls[k];
      o.cnt    = m_cnt[k];
   endtask

   task automatic modelClock(input int k);
      bit     haz, bub;
      int     as, ac, bs, bc;
      instr_t issued;
      if (!rst_n) begin
         modelReset(k);
      end else if (!mem_busy) begin
         haz = model_hazard(k);
         bub = model_bubble(k);
         modelSource(k, id_rs_used, id_rs_addr, as, ac);
         modelSource(k, id_rt_used, id_rt_addr, bs, bc);
         issued = bub ? instr_t'('0) : instr_t'{1'b1, id_wr_en, id_wr_addr, id_res_cls};
         in_mem[k] = in_ex[k];
         in_ex[k]  = issued;
         m_asel[k] = as; m_acls[k] = ac; m_bsel[k] = bs; m_bcls[k] = bc;
         if (haz && !flush && m_cnt[k] < cnt_max[k])
            m_cnt[k]++;
      end
   endtask

   // One decode cycle: drive, record the expected response, then advance the model at the edge
   task automatic applyStimulus(input bit v, input int rs, input bit rsu, input int rt,
                                input bit rtu, input bit wr, input int wa, input int cls,
                                input bit busy, input bit fl, input bit rn);
      obs_t o0, o1;
      id_valid   = v;
      id_rs_addr = 3'(rs);
      id_rs_used = rsu;
      id_rt_addr = 3'(rt);
      id_rt_used = rtu;
      id_wr_en   = wr;
      id_wr_addr = 3'(wa);
      id_res_cls = 2'(cls);
      mem_busy   = busy;
      flush      = fl;
      rst_n      = rn;
      if (!rn) begin
         modelReset(0);
         modelReset(1);
      end
      modelExpect(0, o0);
      modelExpect(1, o1);
      exp_q0.push_back(o0);
      exp_q1.push_back(o1);
      @(posedge clk);
      modelClock(0);
      modelClock(1);
      cycle++;
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic checkOutput(input string name, input int k, input logic [7:0] act,
                              input int expv);
      checks++;
      if (act !== 8'(expv)) begin
         errors++;
         $display("[TB] FAIL %s dut%0d cycle %0d: got %0d expected %0d",
                  name, k, cycle, act, expv);
      end
   endtask

   // Stimulus: directed sequences from the hazard scenarios, then random traffic
   initial begin
      rst_n = 1'b0;
      id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
      id_wr_en = 0; id_wr_addr = 0; id_res_cls = 0; mem_busy = 0; flush = 0;
      modelReset(0);
      modelReset(1);
      @(posedge clk);
      #1;
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(1);
      // ADD r1 ; ADD r2,r1,r3
      applyStimulus(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 1);
      applyStimulus(1, 1, 1, 3, 1, 1, 2, 0, 0, 0, 1);
      nop(3);
      // LD r1 ; ADD r2,r1,r1 held for the stall
      applyStimulus(1, 5, 1, 0, 0, 1, 1, 3, 0, 0, 1);
      repeat (3) applyStimulus(1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 1);
      nop(3);
      // ADD r4 ; SUB r5,r4,r6 held
      applyStimulus(1, 2, 1, 3, 1, 1, 4, 0, 0, 0, 1);
      repeat (3) applyStimulus(1, 4, 1, 6, 1, 1, 5, 0, 0, 0, 1);
      nop(3);
      // LD r1 ; dependent ADD killed by flush
      applyStimulus(1, 5, 1, 0, 0, 1, 1, 3, 0, 0, 1);
      applyStimulus(1, 1, 1, 1, 1, 1, 2, 0, 0, 1, 1);
      nop(3);
      // LD r1 ; dependent ADD with mem_busy during the stall
      applyStimulus(1, 5, 1, 0, 0, 1, 1, 3, 0, 0, 1);
      repeat (3) applyStimulus(1, 1, 1, 2, 1, 1, 2, 0, 1, 0, 1);
      repeat (3) applyStimulus(1, 1, 1, 2, 1, 1, 2, 0, 0, 0, 1);
      nop(3);
      // producer writes r0 ; consumer reads r0
      applyStimulus(1, 2, 1, 3, 1, 1, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 1, 0, 1, 1, 3, 0, 0, 0, 1);
      nop(3);
      // LD r1 ; dependent ADD, reset pulsed while it is stalled
      applyStimulus(1, 5, 1, 0, 0, 1, 1, 3, 0, 0, 1);
      applyStimulus(1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 1);
      repeat (2) applyStimulus(1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 0);
      repeat (2) applyStimulus(1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 1);
      nop(2);
      // Random traffic over a small register window so dependences are frequent
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 9) != 0,
                       $urandom_range(0, 3), $urandom_range(0, 4) != 0,
                       $urandom_range(0, 3), $urandom_range(0, 4) != 0,
                       $urandom_range(0, 4) != 0, $urandom_range(0, 3),
                       $urandom_range(0, 3),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 149) != 0);
      end
      drv_done = 1'b1;
   end

   // Monitor: every cycle the units present a response; compare it with the queued expectation
   initial begin
      obs_t e0, e1;
      while (!(drv_done && exp_q0.size() == 0)) begin
         @(negedge clk);
         if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
            e0 = exp_q0.pop_front();
            e1 = exp_q1.pop_front();
            checkOutput("stall",     0, {7'd0, stall0},  e0.stall);
            checkOutput("bubble",    0, {7'd0, bubble0}, e0.bubble);
            checkOutput("fwd_a_sel", 0, {6'd0, a_sel0},  e0.a_sel);
            checkOutput("fwd_a_cls", 0, {6'd0, a_cls0},  e0.a_cls);
            checkOutput("fwd_b_sel", 0, {6'd0, b_sel0},  e0.b_sel);
            checkOutput("fwd_b_cls", 0, {6'd0, b_cls0},  e0.b_cls);
            checkOutput("stall_cnt", 0, cnt0,            e0.cnt);
            checkOutput("stall",     1, {7'd0, stall1},  e1.stall);
            checkOutput("bubble",    1, {7'd0, bubble1}, e1.bubble);
            checkOutput("fwd_a_sel", 1, {6'd0, a_sel1},  e1.a_sel);
            checkOutput("fwd_a_cls", 1, {6'd0, a_cls1},  e1.a_cls);
            checkOutput("fwd_b_sel", 1, {6'd0, b_sel1},  e1.b_sel);
            checkOutput("fwd_b_cls", 1, {6'd0, b_cls1},  e1.b_cls);
            checkOutput("stall_cnt", 1, {6'd0, cnt1},    e1.cnt);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends with a summary
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
